// File: rtl/micro_sequencer_if.sv
// Bus between the micro-sequencer and the datapath.
// It carries the opcode, the ALU flags, the loader handshake and the control word.
interface micro_sequencer_if;
    logic [3:0] inst;
    logic       c_in;
    logic       z_in;
    logic       prog_req;
    logic       prog_ack;
    logic       AI, AO, BI, SU, EO, CE, CO, J, MI, RI, RO, II, IO, OI, hlt;
    logic [2:0] step;
    logic       cflag;
    logic       zflag;

    modport master (
        input  inst, c_in, z_in, prog_req,
        output prog_ack, AI, AO, BI, SU, EO, CE, CO, J, MI, RI, RO, II, IO, OI, hlt,
        output step, cflag, zflag
    );

    modport slave (
        output inst, c_in, z_in, prog_req,
        input  prog_ack, AI, AO, BI, SU, EO, CE, CO, J, MI, RI, RO, II, IO, OI, hlt,
        input  step, cflag, zflag
    );
endinterface

// File: rtl/micro_sequencer.sv
// Variable-length micro-sequencer for an 8-bit breadboard-style CPU.
// It includes RUN/HALT/PROG arbitration and ALU flag latching.
module micro_sequencer (
    input  logic              clk,
    input  logic              clearbar,
    micro_sequencer_if.master bus
);
    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_HALT = 2'd1,
        S_PROG = 2'd2
    } state_t;

    localparam logic [14:0] C_AI  = 15'h4000;
    localparam logic [14:0] C_AO  = 15'h2000;
    localparam logic [14:0] C_BI  = 15'h1000;
    localparam logic [14:0] C_SU  = 15'h0800;
    localparam logic [14:0] C_EO  = 15'h0400;
    localparam logic [14:0] C_CE  = 15'h0200;
    localparam logic [14:0] C_CO  = 15'h0100;
    localparam logic [14:0] C_J   = 15'h0080;
    localparam logic [14:0] C_MI  = 15'h0040;
    localparam logic [14:0] C_RI  = 15'h0020;
    localparam logic [14:0] C_RO  = 15'h0010;
    localparam logic [14:0] C_II  = 15'h0008;
    localparam logic [14:0] C_IO  = 15'h0004;
    localparam logic [14:0] C_OI  = 15'h0002;
    localparam logic [14:0] C_HLT = 15'h0001;

    localparam logic [3:0] OP_LDA = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_STA = 4'b0100;
    localparam logic [3:0] OP_LDI = 4'b0101;
    localparam logic [3:0] OP_JMP = 4'b0110;
    localparam logic [3:0] OP_JC  = 4'b0111;
    localparam logic [3:0] OP_JZ  = 4'b1000;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    state_t      state_q, state_d;
    logic [2:0]  step_q, step_d;
    logic        cflag_q, cflag_d;
    logic        zflag_q, zflag_d;
    logic        started_q, started_d;
    logic [14:0] ctrl;
    logic        last_step;
    logic        flag_load;

    // started_q keeps the control word dark until the first edge after reset.
    always_comb begin
        ctrl      = '0;
        last_step = 1'b0;
        flag_load = 1'b0;
        if (started_q && state_q == S_RUN) begin
            case (step_q)
                3'd0: ctrl = C_CO | C_MI;
                3'd1: ctrl = C_RO | C_II | C_CE;
                3'd2: begin
                    last_step = 1'b1;
                    case (bus.inst)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            ctrl      = C_IO | C_MI;
                            last_step = 1'b0;
                        end
                        OP_LDI: ctrl = C_IO | C_AI;
                        OP_JMP: ctrl = C_IO | C_J;
                        OP_JC:  if (cflag_q) ctrl = C_IO | C_J;
                        OP_JZ:  if (zflag_q) ctrl = C_IO | C_J;
                        OP_OUT: ctrl = C_AO | C_OI;
                        OP_HLT: ctrl = C_HLT;
                        default: ctrl = '0;
                    endcase
                end
                3'd3: begin
                    last_step = 1'b1;
                    case (bus.inst)
                        OP_LDA: ctrl = C_RO | C_AI;
                        OP_ADD: begin
                            ctrl      = C_RO | C_BI;
                            last_step = 1'b0;
                        end
                        OP_SUB: begin
                            ctrl      = C_RO | C_BI | C_SU;
                            last_step = 1'b0;
                        end
                        OP_STA: ctrl = C_AO | C_RI;
                        default: ctrl = '0;
                    endcase
                end
                3'd4: begin
                    last_step = 1'b1;
                    case (bus.inst)
                        OP_ADD: begin
                            ctrl      = C_EO | C_AI;
                            flag_load = 1'b1;
                        end
                        OP_SUB: begin
                            ctrl      = C_EO | C_AI | C_SU;
                            flag_load = 1'b1;
                        end
                        default: ctrl = '0;
                    endcase
                end
                default: ctrl = '0;
            endcase
        end else if (state_q == S_HALT) begin
            ctrl = C_HLT;
        end
    end

    // The loader request is only honoured on instruction boundaries or while halted.
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        cflag_d   = cflag_q;
        zflag_d   = zflag_q;
        started_d = 1'b1;
        if (!started_q) begin
            state_d = S_RUN;
            step_d  = 3'd0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (step_q > 3'd4) begin
                        step_d = 3'd0;
                    end else begin
                        if (flag_load) begin
                            cflag_d = bus.c_in;
                            zflag_d = bus.z_in;
                        end
                        if (last_step) begin
                            step_d = 3'd0;
                            if (bus.prog_req) begin
                                state_d = S_PROG;
                            end else if (step_q == 3'd2 && bus.inst == OP_HLT) begin
                                state_d = S_HALT;
                            end
                        end else begin
                            step_d = step_q + 3'd1;
                        end
                    end
                end
                S_HALT: begin
                    step_d = 3'd0;
                    if (bus.prog_req) state_d = S_PROG;
                end
                S_PROG: begin
                    step_d = 3'd0;
                    if (!bus.prog_req) state_d = S_RUN;
                end
                default: begin
                    state_d = S_RUN;
                    step_d  = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge clearbar) begin
        if (!clearbar) begin
            state_q   <= S_RUN;
            step_q    <= 3'd0;
            cflag_q   <= 1'b0;
            zflag_q   <= 1'b0;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            cflag_q   <= cflag_d;
            zflag_q   <= zflag_d;
            started_q <= started_d;
        end
    end

    assign {bus.AI, bus.AO, bus.BI, bus.SU, bus.EO, bus.CE, bus.CO, bus.J,
            bus.MI, bus.RI, bus.RO, bus.II, bus.IO, bus.OI, bus.hlt} = ctrl;
    assign bus.prog_ack = (state_q == S_PROG);
    assign bus.step     = step_q;
    assign bus.cflag    = cflag_q;
    assign bus.zflag    = zflag_q;
endmodule

// File: tb/tb_micro_sequencer.sv
// Directed scoreboard bench for micro_sequencer.
// Stimulus queues hand-computed expectations and a negedge monitor compares them.
module tb_micro_sequencer;
    localparam logic [14:0] W_AI  = 15'h4000;
    localparam logic [14:0] W_AO  = 15'h2000;
    localparam logic [14:0] W_BI  = 15'h1000;
    localparam logic [14:0] W_SU  = 15'h0800;
    localparam logic [14:0] W_EO  = 15'h0400;
    localparam logic [14:0] W_CE  = 15'h0200;
    localparam logic [14:0] W_CO  = 15'h0100;
    localparam logic [14:0] W_J   = 15'h0080;
    localparam logic [14:0] W_MI  = 15'h0040;
    localparam logic [14:0] W_RI  = 15'h0020;
    localparam logic [14:0] W_RO  = 15'h0010;
    localparam logic [14:0] W_II  = 15'h0008;
    localparam logic [14:0] W_IO  = 15'h0004;
    localparam logic [14:0] W_OI  = 15'h0002;
    localparam logic [14:0] W_HLT = 15'h0001;
    localparam logic [14:0] T0W   = W_CO | W_MI;
    localparam logic [14:0] T1W   = W_RO | W_II | W_CE;

    localparam logic [3:0] LDA = 4'b0001, ADD = 4'b0010, SUB = 4'b0011, STA = 4'b0100;
    localparam logic [3:0] LDI = 4'b0101, JMP = 4'b0110, JC = 4'b0111, JZ = 4'b1000;
    localparam logic [3:0] OUT = 4'b1110, HLT = 4'b1111, NOP = 4'b1010;

    typedef struct {
        string       name;
        int          cyc;
        logic [14:0] word;
        logic [2:0]  st;
        logic        cf;
        logic        zf;
        logic        ack;
    } exp_t;

    logic clk = 1'b0;
    logic clearbar;
    int   cycNum = 0;
    int   checkCount = 0;
    int   passCount = 0;
    logic expCf, expZf;
    exp_t expQ[$];
    event sampleEv;

    micro_sequencer_if bus();

    micro_sequencer dut (
        .clk      (clk),
        .clearbar (clearbar),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycNum = cycNum + 1;

    task automatic checkOutput(input exp_t e);
        logic [14:0] w;
        w = {bus.AI, bus.AO, bus.BI, bus.SU, bus.EO, bus.CE, bus.CO, bus.J,
             bus.MI, bus.RI, bus.RO, bus.II, bus.IO, bus.OI, bus.hlt};
        checkCount++;
        if ({w, bus.step, bus.cflag, bus.zflag, bus.prog_ack} !== {e.word, e.st, e.cf, e.zf, e.ack}) begin
            $display("[TB] FAIL %s: got ctrl=%h step=%0d c=%b z=%b ack=%b, expected ctrl=%h step=%0d c=%b z=%b ack=%b",
                     e.name, w, bus.step, bus.cflag, bus.zflag, bus.prog_ack,
                     e.word, e.st, e.cf, e.zf, e.ack);
        end else begin
            passCount++;
        end
    endtask

    always @(negedge clk) begin
        while (expQ.size() > 0 && expQ[0].cyc == cycNum) checkOutput(expQ.pop_front());
    end

    // Entries with a negative cycle tag are asynchronous snapshots, e.g. during reset.
    always begin
        @(sampleEv);
        while (expQ.size() > 0 && expQ[0].cyc < 0) checkOutput(expQ.pop_front());
    end

    task automatic pushExp(input string nm, input logic [14:0] w, input logic [2:0] st,
                           input logic ack, input int cyc);
        exp_t e;
        e.name = nm;
        e.cyc  = cyc;
        e.word = w;
        e.st   = st;
        e.cf   = expCf;
        e.zf   = expZf;
        e.ack  = ack;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input string nm, input logic [3:0] op, input logic req,
                                 input logic [14:0] w, input logic [2:0] st, input logic ack);
        bus.inst     = op;
        bus.prog_req = req;
        pushExp(nm, w, st, ack, cycNum);
        @(posedge clk);
        #2;
    endtask

    task automatic fetch(input string nm, input logic [3:0] op);
        applyStimulus({nm, "_t0"}, op, 1'b0, T0W, 3'd0, 1'b0);
        applyStimulus({nm, "_t1"}, op, 1'b0, T1W, 3'd1, 1'b0);
    endtask

    initial begin
        clearbar     = 1'b1;
        bus.inst     = 4'd0;
        bus.c_in     = 1'b0;
        bus.z_in     = 1'b0;
        bus.prog_req = 1'b0;
        expCf        = 1'b0;
        expZf        = 1'b0;

        #1 clearbar = 1'b0;
        #1 pushExp("reset_async", 15'h0, 3'd0, 1'b0, -1);
        -> sampleEv;
        #1;
        @(posedge clk);
        #2 clearbar = 1'b1;
        applyStimulus("release_idle", NOP, 1'b0, 15'h0, 3'd0, 1'b0);

        fetch("add_c1z0", ADD);
        applyStimulus("add_t2", ADD, 1'b0, W_IO | W_MI, 3'd2, 1'b0);
        applyStimulus("add_t3", ADD, 1'b0, W_RO | W_BI, 3'd3, 1'b0);
        bus.c_in = 1'b1;
        bus.z_in = 1'b0;
        applyStimulus("add_t4", ADD, 1'b0, W_EO | W_AI, 3'd4, 1'b0);
        expCf = 1'b1;
        expZf = 1'b0;

        fetch("jc_taken", JC);
        applyStimulus("jc_taken_t2", JC, 1'b0, W_IO | W_J, 3'd2, 1'b0);

        fetch("sub_c0z1", SUB);
        applyStimulus("sub_t2", SUB, 1'b0, W_IO | W_MI, 3'd2, 1'b0);
        applyStimulus("sub_t3", SUB, 1'b0, W_RO | W_BI | W_SU, 3'd3, 1'b0);
        bus.c_in = 1'b0;
        bus.z_in = 1'b1;
        applyStimulus("sub_t4", SUB, 1'b0, W_EO | W_AI | W_SU, 3'd4, 1'b0);
        expCf = 1'b0;
        expZf = 1'b1;

        fetch("jc_not_taken", JC);
        applyStimulus("jc_not_taken_t2", JC, 1'b0, 15'h0, 3'd2, 1'b0);
        fetch("jz_taken", JZ);
        applyStimulus("jz_taken_t2", JZ, 1'b0, W_IO | W_J, 3'd2, 1'b0);

        fetch("lda", LDA);
        applyStimulus("lda_t2", LDA, 1'b0, W_IO | W_MI, 3'd2, 1'b0);
        applyStimulus("lda_t3", LDA, 1'b0, W_RO | W_AI, 3'd3, 1'b0);
        fetch("sta", STA);
        applyStimulus("sta_t2", STA, 1'b0, W_IO | W_MI, 3'd2, 1'b0);
        applyStimulus("sta_t3", STA, 1'b0, W_AO | W_RI, 3'd3, 1'b0);
        fetch("ldi", LDI);
        applyStimulus("ldi_t2", LDI, 1'b0, W_IO | W_AI, 3'd2, 1'b0);
        fetch("jmp", JMP);
        applyStimulus("jmp_t2", JMP, 1'b0, W_IO | W_J, 3'd2, 1'b0);
        fetch("out", OUT);
        applyStimulus("out_t2", OUT, 1'b0, W_AO | W_OI, 3'd2, 1'b0);

        fetch("add_c1z1", ADD);
        applyStimulus("add11_t2", ADD, 1'b0, W_IO | W_MI, 3'd2, 1'b0);
        applyStimulus("add11_t3", ADD, 1'b0, W_RO | W_BI, 3'd3, 1'b0);
        bus.c_in = 1'b1;
        bus.z_in = 1'b1;
        applyStimulus("add11_t4", ADD, 1'b0, W_EO | W_AI, 3'd4, 1'b0);
        expCf = 1'b1;
        expZf = 1'b1;
        bus.c_in = 1'b0;
        bus.z_in = 1'b0;

        fetch("nop", NOP);
        applyStimulus("nop_t2", NOP, 1'b0, 15'h0, 3'd2, 1'b0);

        // Request raised at T1 of LDA must wait for the instruction end.
        applyStimulus("ldareq_t0", LDA, 1'b0, T0W, 3'd0, 1'b0);
        applyStimulus("ldareq_t1", LDA, 1'b1, T1W, 3'd1, 1'b0);
        applyStimulus("ldareq_t2", LDA, 1'b1, W_IO | W_MI, 3'd2, 1'b0);
        applyStimulus("ldareq_t3", LDA, 1'b1, W_RO | W_AI, 3'd3, 1'b0);
        applyStimulus("prog_grant", LDA, 1'b1, 15'h0, 3'd0, 1'b1);
        applyStimulus("prog_hold", LDA, 1'b1, 15'h0, 3'd0, 1'b1);
        applyStimulus("prog_req_drop", LDA, 1'b0, 15'h0, 3'd0, 1'b1);
        applyStimulus("prog_exit_t0", LDA, 1'b0, T0W, 3'd0, 1'b0);
        applyStimulus("prog_exit_t1", LDA, 1'b0, T1W, 3'd1, 1'b0);
        applyStimulus("prog_exit_t2", LDA, 1'b0, W_IO | W_MI, 3'd2, 1'b0);
        applyStimulus("prog_exit_t3", LDA, 1'b0, W_RO | W_AI, 3'd3, 1'b0);

        fetch("hlt", HLT);
        applyStimulus("hlt_t2", HLT, 1'b0, W_HLT, 3'd2, 1'b0);
        for (int i = 0; i < 20; i++) applyStimulus("halt_hold", HLT, 1'b0, W_HLT, 3'd0, 1'b0);
        applyStimulus("halt_req", HLT, 1'b1, W_HLT, 3'd0, 1'b0);
        applyStimulus("halt_grant", HLT, 1'b1, 15'h0, 3'd0, 1'b1);
        applyStimulus("halt_req_drop", HLT, 1'b0, 15'h0, 3'd0, 1'b1);

        fetch("hlt_req", HLT);
        applyStimulus("hltreq_t2", HLT, 1'b1, W_HLT, 3'd2, 1'b0);
        applyStimulus("hltreq_grant", HLT, 1'b1, 15'h0, 3'd0, 1'b1);
        applyStimulus("hltreq_drop", HLT, 1'b0, 15'h0, 3'd0, 1'b1);

        // Asynchronous reset pulse inside ADD T3 with both flags set.
        fetch("add_rst", ADD);
        applyStimulus("addrst_t2", ADD, 1'b0, W_IO | W_MI, 3'd2, 1'b0);
        pushExp("addrst_t3", W_RO | W_BI, 3'd3, 1'b0, cycNum);
        #5 clearbar = 1'b0;
        expCf = 1'b0;
        expZf = 1'b0;
        #1 pushExp("reset_mid_add", 15'h0, 3'd0, 1'b0, -1);
        -> sampleEv;
        #1 clearbar = 1'b1;
        @(posedge clk);
        #2;
        applyStimulus("restart_t0", ADD, 1'b0, T0W, 3'd0, 1'b0);
        applyStimulus("restart_t1", ADD, 1'b0, T1W, 3'd1, 1'b0);

        @(posedge clk);
        #2;
        while (expQ.size() > 0) begin
            exp_t e;
            e = expQ.pop_front();
            checkCount++;
            $display("[TB] FAIL %s: got no sample, expected one at cycle %0d", e.name, e.cyc);
        end
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
